// File: rtl/stage_operand.sv
// Operand stage between decode and execute: forwarding, predication, hazard stall and jump shadow.
// Optional performance counters are compiled in when STAGE_OPERAND_PERFCNT_EN is defined.
module stage_operand #(
  parameter int XLEN   = 32,
  parameter int RADDR  = 4,
  parameter int NFWD   = 2,
  parameter int SHADOW = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [XLEN-1:0]        pred_val,
  input  logic                   pred_inv,
  input  logic [RADDR-1:0]       a_addr,
  input  logic [RADDR-1:0]       b_addr,
  input  logic [RADDR-1:0]       m_addr,
  input  logic                   a_used,
  input  logic                   b_used,
  input  logic                   m_used,
  input  logic [XLEN-1:0]        a_val,
  input  logic [XLEN-1:0]        b_val,
  input  logic [XLEN-1:0]        m_val,
  input  logic                   use_imm,
  input  logic [XLEN-1:0]        imm,
  input  logic [RADDR-1:0]       dest_in,
  input  logic [3:0]             aluop_in,
  input  logic                   is_mem,
  input  logic                   is_mem_write,
  input  logic                   is_jump,
  input  logic [NFWD-1:0]        fwd_pending,
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD*RADDR-1:0]  fwd_addr,
  input  logic [NFWD*XLEN-1:0]   fwd_data,
  input  logic                   stall_in,
  output logic                   stall,
  output logic                   discard,
  output logic                   out_valid,
  output logic [XLEN-1:0]        pc,
  output logic [XLEN-1:0]        reg_a,
  output logic [XLEN-1:0]        reg_b,
  output logic [XLEN-1:0]        reg_m,
  output logic [RADDR-1:0]       dest,
  output logic [3:0]             aluop,
  output logic                   mem,
  output logic                   mem_write,
  output logic                   jump
`ifdef STAGE_OPERAND_PERFCNT_EN
  ,
  output logic [31:0]            hazard_cycles,
  output logic [31:0]            bubble_cycles
`endif
);

  localparam int SW = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);
  localparam logic [SW-1:0] SHADOW_INIT = SW'(SHADOW);

  typedef struct packed {
    logic            hazard;
    logic [XLEN-1:0] val;
  } operand_t;

  // Lowest-numbered pending port that targets the address owns it; address 0 never forwards.
  function automatic operand_t resolve(
    input logic [RADDR-1:0]      addr,
    input logic [XLEN-1:0]       rf_val,
    input logic [NFWD-1:0]       pend,
    input logic [NFWD-1:0]       vld,
    input logic [NFWD*RADDR-1:0] faddr,
    input logic [NFWD*XLEN-1:0]  fdata
  );
    operand_t r;
    logic     found;
    r.hazard = 1'b0;
    r.val    = rf_val;
    found    = 1'b0;
    for (int i = 0; i < NFWD; i++) begin
      if (!found && pend[i] && (faddr[i*RADDR +: RADDR] == addr) && (addr != '0)) begin
        found = 1'b1;
        if (vld[i]) r.val    = fdata[i*XLEN +: XLEN];
        else        r.hazard = 1'b1;
      end
    end
    return r;
  endfunction

  operand_t op_a, op_b, op_m;
  logic     hazard, pred, emit;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  pc_q, pc_d, reg_a_q, reg_a_d, reg_b_q, reg_b_d, reg_m_q, reg_m_d;
  logic [RADDR-1:0] dest_q, dest_d;
  logic [3:0]       aluop_q, aluop_d;
  logic             mem_q, mem_d, mem_write_q, mem_write_d, jump_q, jump_d;
  logic [SW-1:0]    shadow_cnt_q, shadow_cnt_d;
  logic             first_cycle_q, first_cycle_d;

  always_comb begin
    op_a   = resolve(a_addr, a_val, fwd_pending, fwd_valid, fwd_addr, fwd_data);
    op_b   = resolve(b_addr, b_val, fwd_pending, fwd_valid, fwd_addr, fwd_data);
    op_m   = resolve(m_addr, m_val, fwd_pending, fwd_valid, fwd_addr, fwd_data);
    hazard = (a_used & op_a.hazard) | (b_used & op_b.hazard) | (m_used & op_m.hazard);
    stall  = stall_in | ~in_valid | hazard;
    pred   = ((pred_val == '0) ^ pred_inv) & ~first_cycle_q;
    emit   = ~stall & pred & (shadow_cnt_q == '0) & ~jump_q;
    discard = (emit & is_jump) | (shadow_cnt_q != '0);
  end

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    out_valid_d   = out_valid_q;
    pc_d          = pc_q;
    reg_a_d       = reg_a_q;
    reg_b_d       = reg_b_q;
    reg_m_d       = reg_m_q;
    dest_d        = dest_q;
    aluop_d       = aluop_q;
    mem_d         = mem_q;
    mem_write_d   = mem_write_q;
    jump_d        = jump_q;
    shadow_cnt_d  = shadow_cnt_q;
    first_cycle_d = first_cycle_q & ~in_valid;

    if (!stall_in) begin
      if (emit) begin
        out_valid_d = 1'b1;
        pc_d        = in_pc;
        reg_a_d     = op_a.val;
        reg_b_d     = use_imm ? imm : op_b.val;
        reg_m_d     = op_m.val;
        dest_d      = dest_in;
        aluop_d     = aluop_in;
        mem_d       = is_mem;
        mem_write_d = is_mem_write;
        jump_d      = is_jump;
      end else begin
        out_valid_d = 1'b0;
        dest_d      = '0;
        mem_d       = 1'b0;
        mem_write_d = 1'b0;
        jump_d      = 1'b0;
      end
    end

    if (emit && is_jump) begin
      shadow_cnt_d = SHADOW_INIT;
    end else if ((shadow_cnt_q != '0) && in_valid && !stall_in) begin
      shadow_cnt_d = shadow_cnt_q - 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      dest_q        <= '0;
      mem_q         <= 1'b0;
      mem_write_q   <= 1'b0;
      jump_q        <= 1'b0;
      shadow_cnt_q  <= '0;
      first_cycle_q <= 1'b1;
    end else begin
      out_valid_q   <= out_valid_d;
      dest_q        <= dest_d;
      mem_q         <= mem_d;
      mem_write_q   <= mem_write_d;
      jump_q        <= jump_d;
      shadow_cnt_q  <= shadow_cnt_d;
      first_cycle_q <= first_cycle_d;
    end
  end

  // NOTE: the data payload is qualified by out_valid, so it is left unreset.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    reg_a_q <= reg_a_d;
    reg_b_q <= reg_b_d;
    reg_m_q <= reg_m_d;
    aluop_q <= aluop_d;
  end

  assign out_valid = out_valid_q;
  assign pc        = pc_q;
  assign reg_a     = reg_a_q;
  assign reg_b     = reg_b_q;
  assign reg_m     = reg_m_q;
  assign dest      = dest_q;
  assign aluop     = aluop_q;
  assign mem       = mem_q;
  assign mem_write = mem_write_q;
  assign jump      = jump_q;

`ifdef STAGE_OPERAND_PERFCNT_EN
  logic [31:0] hazard_cycles_q, hazard_cycles_d, bubble_cycles_q, bubble_cycles_d;

  // Both counters saturate at all-ones rather than wrapping.
  always_comb begin
    hazard_cycles_d = hazard_cycles_q;
    bubble_cycles_d = bubble_cycles_q;
    if (in_valid && !stall_in && hazard && (hazard_cycles_q != '1))
      hazard_cycles_d = hazard_cycles_q + 32'd1;
    if (!stall_in && !emit && (bubble_cycles_q != '1))
      bubble_cycles_d = bubble_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_cycles_q <= '0;
      bubble_cycles_q <= '0;
    end else begin
      hazard_cycles_q <= hazard_cycles_d;
      bubble_cycles_q <= bubble_cycles_d;
    end
  end

  assign hazard_cycles = hazard_cycles_q;
  assign bubble_cycles = bubble_cycles_q;
`endif

endmodule

// File: tb/tb_stage_operand.sv
// Self-checking bench for stage_operand (SHADOW=2): directed scenarios plus randomized traffic
// compared with a cycle-level behavioural model of the stage.
module tb_stage_operand;
  localparam int XLEN = 32, RADDR = 4, NFWD = 2, SHADOW = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, pred_inv, a_used, b_used, m_used, use_imm;
  logic is_mem, is_mem_write, is_jump, stall_in;
  logic [XLEN-1:0] in_pc, pred_val, a_val, b_val, m_val, imm;
  logic [RADDR-1:0] a_addr, b_addr, m_addr, dest_in;
  logic [3:0] aluop_in;
  logic [NFWD-1:0] fwd_pending, fwd_valid;
  logic [RADDR-1:0] fa [NFWD];
  logic [XLEN-1:0]  fd [NFWD];
  logic [NFWD*RADDR-1:0] fwd_addr;
  logic [NFWD*XLEN-1:0]  fwd_data;
  logic stall, discard, out_valid, mem, mem_write, jump;
  logic [XLEN-1:0] pc, reg_a, reg_b, reg_m;
  logic [RADDR-1:0] dest;
  logic [3:0] aluop;
`ifdef STAGE_OPERAND_PERFCNT_EN
  logic [31:0] hazard_cycles, bubble_cycles;
`endif

  assign fwd_addr = {fa[1], fa[0]};
  assign fwd_data = {fd[1], fd[0]};

  always #5 clk = ~clk;

  stage_operand #(.XLEN(XLEN), .RADDR(RADDR), .NFWD(NFWD), .SHADOW(SHADOW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
    .pred_val(pred_val), .pred_inv(pred_inv),
    .a_addr(a_addr), .b_addr(b_addr), .m_addr(m_addr),
    .a_used(a_used), .b_used(b_used), .m_used(m_used),
    .a_val(a_val), .b_val(b_val), .m_val(m_val),
    .use_imm(use_imm), .imm(imm), .dest_in(dest_in), .aluop_in(aluop_in),
    .is_mem(is_mem), .is_mem_write(is_mem_write), .is_jump(is_jump),
    .fwd_pending(fwd_pending), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .stall_in(stall_in),
    .stall(stall), .discard(discard), .out_valid(out_valid), .pc(pc),
    .reg_a(reg_a), .reg_b(reg_b), .reg_m(reg_m), .dest(dest), .aluop(aluop),
    .mem(mem), .mem_write(mem_write), .jump(jump)
`ifdef STAGE_OPERAND_PERFCNT_EN
    , .hazard_cycles(hazard_cycles), .bubble_cycles(bubble_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_first, m_out_valid, m_mem, m_mem_write, m_jump;
  int m_shadow;
  logic [XLEN-1:0] m_pc, m_reg_a, m_reg_b, m_reg_m;
  logic [RADDR-1:0] m_dest;
  logic [3:0] m_aluop;
  longint m_hazard_cnt, m_bubble_cnt;
  bit exp_stall, exp_discard, exp_emit, exp_hazard;
  logic [XLEN-1:0] res_a, res_b, res_m;

  // Returns {hazard, value}: first pending port on the address in priority order decides.
  function automatic logic [XLEN:0] ref_operand(input logic [RADDR-1:0] addr, input logic [XLEN-1:0] rf);
    if (addr == 0) return {1'b0, rf};
    for (int i = 0; i < NFWD; i++)
      if (fwd_pending[i] && fa[i] == addr) return fwd_valid[i] ? {1'b0, fd[i]} : {1'b1, rf};
    return {1'b0, rf};
  endfunction

  function automatic void model_eval();
    logic [XLEN:0] ra, rb, rm;
    bit pred_ok;
    ra = ref_operand(a_addr, a_val);
    rb = ref_operand(b_addr, b_val);
    rm = ref_operand(m_addr, m_val);
    res_a = ra[XLEN-1:0]; res_b = rb[XLEN-1:0]; res_m = rm[XLEN-1:0];
    exp_hazard  = (a_used && ra[XLEN]) || (b_used && rb[XLEN]) || (m_used && rm[XLEN]);
    exp_stall   = stall_in || !in_valid || exp_hazard;
    pred_ok     = ((pred_val == 0) != pred_inv) && !m_first;
    exp_emit    = !exp_stall && pred_ok && (m_shadow == 0) && !m_jump;
    exp_discard = (exp_emit && is_jump) || (m_shadow != 0);
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  // Advances the model across one rising edge using the inputs present before it.
  task automatic tick();
    bit n_first;
    int n_shadow;
    model_eval();
    n_first  = m_first && !in_valid;
    n_shadow = m_shadow;
    if (exp_emit && is_jump) n_shadow = SHADOW;
    else if (m_shadow > 0 && in_valid && !stall_in) n_shadow = m_shadow - 1;
    if (in_valid && !stall_in && exp_hazard && m_hazard_cnt < 64'hFFFF_FFFF) m_hazard_cnt++;
    if (!stall_in && !exp_emit && m_bubble_cnt < 64'hFFFF_FFFF) m_bubble_cnt++;
    if (rst) begin
      m_out_valid = 0; m_dest = 0; m_mem = 0; m_mem_write = 0; m_jump = 0;
      n_first = 1; n_shadow = 0; m_hazard_cnt = 0; m_bubble_cnt = 0;
    end else if (!stall_in) begin
      if (exp_emit) begin
        m_out_valid = 1; m_pc = in_pc; m_reg_a = res_a; m_reg_b = use_imm ? imm : res_b;
        m_reg_m = res_m; m_dest = dest_in; m_aluop = aluop_in; m_mem = is_mem;
        m_mem_write = is_mem_write; m_jump = is_jump;
      end else begin
        m_out_valid = 0; m_dest = 0; m_mem = 0; m_mem_write = 0; m_jump = 0;
      end
    end
    m_first  = n_first;
    m_shadow = n_shadow;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; in_valid = 0; in_pc = 0; pred_val = 0; pred_inv = 0;
    a_addr = 0; b_addr = 0; m_addr = 0; a_used = 0; b_used = 0; m_used = 0;
    a_val = 0; b_val = 0; m_val = 0; use_imm = 0; imm = 0; dest_in = 0; aluop_in = 0;
    is_mem = 0; is_mem_write = 0; is_jump = 0; fwd_pending = 0; fwd_valid = 0;
    fa[0] = 0; fa[1] = 0; fd[0] = 0; fd[1] = 0; stall_in = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    settle();
    checks++;
    if ({out_valid, dest, mem, mem_write, jump} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%0d m=%b mw=%b j=%b exp all zero", out_valid, dest, mem, mem_write, jump);
    end
    checks++;
    if (stall !== 1'b1 || discard !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb got stall=%b discard=%b exp 1/0", stall, discard);
    end
  endtask

  task automatic test_first_cycle();
    in_valid = 1; aluop_in = 4'h3; a_val = 5; b_val = 7; dest_in = 2; in_pc = 32'h40;
    settle();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_cycle_bubble got out_valid=%b exp 0", out_valid);
    end
    in_pc = 32'h44;
    settle();
    tick();
    checks++;
    if (out_valid !== 1'b1 || reg_a !== 5 || reg_b !== 7 || aluop !== 4'h3 || dest !== 2 || pc !== 32'h44) begin
      errors++;
      $display("FAIL first_emit got v=%b a=%0d b=%0d op=%0d d=%0d pc=%h exp 1/5/7/3/2/44",
               out_valid, reg_a, reg_b, aluop, dest, pc);
    end
  endtask

  task automatic test_forwarding();
    a_addr = 3; a_used = 1; fwd_pending = 2'b11; fwd_valid = 2'b11;
    fa[0] = 3; fa[1] = 3; fd[0] = 32'hAA; fd[1] = 32'hBB;
    settle();
    tick();
    checks++;
    if (out_valid !== 1'b1 || reg_a !== 32'hAA) begin
      errors++;
      $display("FAIL fwd_priority got v=%b reg_a=%h exp 1/aa", out_valid, reg_a);
    end
    fwd_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL fwd_hazard_stall cycle %0d got %b exp 1", i, stall);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || dest !== 0) begin
        errors++;
        $display("FAIL fwd_hazard_bubble cycle %0d got v=%b d=%0d exp 0/0", i, out_valid, dest);
      end
    end
    fwd_valid = 2'b11; fd[0] = 32'hCC;
    settle();
    tick();
    checks++;
    if (out_valid !== 1'b1 || reg_a !== 32'hCC) begin
      errors++;
      $display("FAIL fwd_resolved got v=%b reg_a=%h exp 1/cc", out_valid, reg_a);
    end
    // Port 0 elsewhere: port 1 supplies the value.
    fa[0] = 5;
    settle();
    tick();
    checks++;
    if (reg_a !== 32'hBB) begin
      errors++;
      $display("FAIL fwd_port1 got reg_a=%h exp bb", reg_a);
    end
    // Register 0 never forwards, even against a pending, not-ready producer.
    a_addr = 0; fa[0] = 0; fwd_valid = 2'b00; a_val = 32'h1234;
    settle();
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL zero_addr_stall got %b exp 0", stall);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || reg_a !== 32'h1234) begin
      errors++;
      $display("FAIL zero_addr_value got v=%b reg_a=%h exp 1/1234", out_valid, reg_a);
    end
    fwd_pending = 0; fwd_valid = 0; a_used = 0;
  endtask

  task automatic test_unused_imm();
    b_used = 0; b_addr = 3; fwd_pending = 2'b01; fwd_valid = 2'b00; fa[0] = 3;
    use_imm = 1; imm = 32'hFFFF_FFF0;
    settle();
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL unused_src_stall got %b exp 0", stall);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || reg_b !== 32'hFFFF_FFF0) begin
      errors++;
      $display("FAIL imm_operand got v=%b reg_b=%h exp 1/fffffff0", out_valid, reg_b);
    end
    b_used = 1;
    settle();
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL used_src_stall got %b exp 1", stall);
    end
    tick();
    b_used = 0; use_imm = 0; fwd_pending = 0; fa[0] = 0;
  endtask

  task automatic test_predication();
    pred_val = 4; pred_inv = 0; dest_in = 9;
    settle();
    tick();
    checks++;
    if (out_valid !== 1'b0 || dest !== 0) begin
      errors++;
      $display("FAIL pred_false got v=%b d=%0d exp 0/0", out_valid, dest);
    end
    pred_inv = 1;
    settle();
    tick();
    checks++;
    if (out_valid !== 1'b1 || dest !== 9) begin
      errors++;
      $display("FAIL pred_inverted got v=%b d=%0d exp 1/9", out_valid, dest);
    end
    pred_val = 0;
    settle();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pred_zero_inv got v=%b exp 0", out_valid);
    end
    pred_inv = 0;
  endtask

  task automatic test_jump_shadow();
    // Let any prior jump state drain before issuing the jump.
    is_jump = 0; in_pc = 32'hF0;
    settle();
    tick();
    is_jump = 1; in_pc = 32'h100;
    settle();
    checks++;
    if (discard !== 1'b1) begin
      errors++;
      $display("FAIL jump_discard_emit got %b exp 1", discard);
    end
    tick();
    checks++;
    if (jump !== 1'b1 || out_valid !== 1'b1 || pc !== 32'h100) begin
      errors++;
      $display("FAIL jump_emit got j=%b v=%b pc=%h exp 1/1/100", jump, out_valid, pc);
    end
    is_jump = 0; stall_in = 1; in_pc = 32'h104;
    settle();
    tick();
    checks++;
    if (jump !== 1'b1 || discard !== 1'b1) begin
      errors++;
      $display("FAIL jump_hold got j=%b discard=%b exp 1/1", jump, discard);
    end
    // Two valid non-stalled inputs are dropped; a stall between them freezes the count.
    for (int i = 0; i < 4; i++) begin
      stall_in = (i == 1 || i == 2);
      in_pc = 32'h104 + 4 * i;
      settle();
      checks++;
      if (discard !== 1'b1) begin
        errors++;
        $display("FAIL shadow_discard step %0d got %b exp 1", i, discard);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || jump !== 1'b0) begin
        errors++;
        $display("FAIL shadow_bubble step %0d got v=%b j=%b exp 0/0", i, out_valid, jump);
      end
    end
    stall_in = 0; in_pc = 32'h120;
    settle();
    checks++;
    if (discard !== 1'b0) begin
      errors++;
      $display("FAIL shadow_end_discard got %b exp 0", discard);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || pc !== 32'h120) begin
      errors++;
      $display("FAIL shadow_end_emit got v=%b pc=%h exp 1/120", out_valid, pc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(63) == 0);
      in_valid = ($urandom_range(7) != 0);
      stall_in = ($urandom_range(5) == 0);
      in_pc = $urandom; pred_val = ($urandom_range(1) == 0) ? 0 : $urandom_range(3);
      pred_inv = ($urandom_range(5) == 0);
      a_addr = RADDR'($urandom_range(3)); b_addr = RADDR'($urandom_range(3));
      m_addr = RADDR'($urandom_range(3));
      a_used = $urandom_range(1); b_used = $urandom_range(1); m_used = $urandom_range(1);
      a_val = $urandom; b_val = $urandom; m_val = $urandom; imm = $urandom;
      use_imm = $urandom_range(1); dest_in = RADDR'($urandom); aluop_in = 4'($urandom);
      is_mem = $urandom_range(1); is_mem_write = $urandom_range(1);
      is_jump = ($urandom_range(7) == 0);
      fwd_pending = NFWD'($urandom); fwd_valid = NFWD'($urandom | $urandom);
      fa[0] = RADDR'($urandom_range(3)); fa[1] = RADDR'($urandom_range(3));
      fd[0] = $urandom; fd[1] = $urandom;
      settle();
      checks++;
      if (stall !== exp_stall || discard !== exp_discard) begin
        errors++;
        $display("FAIL rand_comb cycle %0d got stall=%b discard=%b exp %b/%b", n, stall, discard, exp_stall, exp_discard);
      end
      tick();
      checks++;
      if (out_valid !== m_out_valid || dest !== m_dest || mem !== m_mem ||
          mem_write !== m_mem_write || jump !== m_jump) begin
        errors++;
        $display("FAIL rand_ctrl cycle %0d got v=%b d=%0d m=%b mw=%b j=%b exp %b/%0d/%b/%b/%b", n,
                 out_valid, dest, mem, mem_write, jump, m_out_valid, m_dest, m_mem, m_mem_write, m_jump);
      end
      if (m_out_valid) begin
        checks++;
        if (pc !== m_pc || reg_a !== m_reg_a || reg_b !== m_reg_b || reg_m !== m_reg_m || aluop !== m_aluop) begin
          errors++;
          $display("FAIL rand_data cycle %0d got pc=%h a=%h b=%h m=%h op=%h exp %h/%h/%h/%h/%h", n,
                   pc, reg_a, reg_b, reg_m, aluop, m_pc, m_reg_a, m_reg_b, m_reg_m, m_aluop);
        end
      end
`ifdef STAGE_OPERAND_PERFCNT_EN
      checks++;
      if (hazard_cycles !== 32'(m_hazard_cnt) || bubble_cycles !== 32'(m_bubble_cnt)) begin
        errors++;
        $display("FAIL rand_perf cycle %0d got h=%0d b=%0d exp %0d/%0d", n, hazard_cycles, bubble_cycles,
                 m_hazard_cnt, m_bubble_cnt);
      end
`endif
    end
    idle_inputs();
  endtask

`ifdef STAGE_OPERAND_PERFCNT_EN
  task automatic test_perfcnt();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (hazard_cycles !== 0 || bubble_cycles !== 0) begin
      errors++;
      $display("FAIL perf_reset got h=%0d b=%0d exp 0/0", hazard_cycles, bubble_cycles);
    end
    in_valid = 1;
    tick();
    a_addr = 3; a_used = 1; fwd_pending = 2'b11; fwd_valid = 2'b10; fa[0] = 3; fa[1] = 3;
    for (int i = 0; i < 3; i++) tick();
    fwd_valid = 2'b11;
    tick();
    checks++;
    if (hazard_cycles !== 3 || bubble_cycles < 3) begin
      errors++;
      $display("FAIL perf_counts got h=%0d b=%0d exp 3/>=3", hazard_cycles, bubble_cycles);
    end
    checks++;
    if (bubble_cycles !== 32'(m_bubble_cnt)) begin
      errors++;
      $display("FAIL perf_bubbles got %0d exp %0d", bubble_cycles, m_bubble_cnt);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    m_first = 1; m_shadow = 0; m_out_valid = 0; m_jump = 0; m_mem = 0; m_mem_write = 0;
    m_dest = 0; m_hazard_cnt = 0; m_bubble_cnt = 0;
    @(negedge clk);
    test_reset();
    test_first_cycle();
    test_forwarding();
    test_unused_imm();
    test_predication();
    test_jump_shadow();
    test_random();
`ifdef STAGE_OPERAND_PERFCNT_EN
    test_perfcnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
